qsm_seq: RTL and testbench
==========================

QSM_SEQ -- requirements
Module: qsm_seq

Interface
REQ-001 Block SHALL have no parameters; all widths below are fixed.
REQ-002 clk_i  in  1  single clock; all logic rising-edge.
REQ-003 rst_n_i  in  1  asynchronous, active-low reset; assertion asynchronous, release synchronous to clk_i.
REQ-004 ctl_reset_i  in  1  soft-reset pulse (one clk_i cycle).
REQ-005 ctl_trig_i  in  1  start pulse (one clk_i cycle).
REQ-006 ctl_last_reg_adr_i  in  4  last front-end register index read per dimension.
REQ-007 ctl_max_dim_no_i  in  4  maximum allowed dimensions; values above 8 are treated as 8.
REQ-008 ctl_read_delay_i  in  10  wait cycles between strobe and sample.
REQ-009 sts_busy_o / sts_done_o / sts_err_many_o / sts_err_fb_o  out  1 each  status flags.
REQ-010 sts_dim_count_o  out  4  dimensions captured in last or current scan.
REQ-011 fe_rd_o  out  1  front-end read strobe; fe_dim_o out 3 and fe_adr_o out 4 give the target.
REQ-012 fe_data_i  in  16  front-end read data; bit 15 is the chain "more dimensions" flag.
REQ-013 fe_valid_i  in  1  front-end response present.
REQ-014 ram_we_o  out  1; ram_addr_o  out  7 = {dim[2:0], reg[3:0]}; ram_data_o  out  16  readout RAM write port, 128x16.

Function
REQ-015 States SHALL be IDLE, STROBE, WAIT, CAPTURE.
REQ-016 IDLE: ctl_trig_i=1 -> STROBE; dim=0, reg=0, dim_count=0; clear done, err_many and err_fb.
REQ-017 Leaving IDLE SHALL latch last_reg_adr, max_dim_no (clamped to 8) and read_delay; later control changes are ignored until the next trigger.
REQ-018 STROBE: assert fe_rd_o for exactly one cycle with fe_dim_o=dim and fe_adr_o=reg. Next state is WAIT if the latched delay > 0, otherwise CAPTURE.
REQ-019 WAIT: stay for exactly the latched delay cycles using a 10-bit down-counter, then go to CAPTURE.
REQ-020 Per-word latency from the strobe cycle to the capture cycle SHALL be delay+1 cycles; the full word takes delay+2 cycles.
REQ-021 CAPTURE with fe_valid_i=1: ram_we_o=1 for one cycle, ram_addr_o={dim,reg}, ram_data_o=fe_data_i.
REQ-022 CAPTURE with fe_valid_i=0: no RAM write; set err_fb; set done; go to IDLE.
REQ-023 CAPTURE with reg<last_reg_adr: reg+1 and go to STROBE.
REQ-024 CAPTURE with reg=last_reg_adr: dim_count = dim+1.
  - If fe_data_i[15]=0: set done and go to IDLE.
  - If fe_data_i[15]=1 and dim+1 < max_dim: dim+1, reg=0, go to STROBE.
  - If fe_data_i[15]=1 and dim+1 >= max_dim: set err_many and done, go to IDLE.
REQ-025 A latched max_dim of 0 SHALL still scan dim 0, and SHALL set err_many if the chain flag is set on its last register.
REQ-026 sts_busy_o SHALL be 1 in every state except IDLE.
REQ-027 done, err_many and err_fb SHALL be sticky until the next accepted trigger, soft reset or rst_n_i.
REQ-028 ctl_trig_i while busy SHALL be ignored.
REQ-029 ctl_reset_i in any state SHALL force IDLE next cycle and clear all status flags and dim_count. Any RAM write in that cycle is suppressed; fe_rd_o is deasserted.
REQ-030 ctl_reset_i and ctl_trig_i in the same cycle: reset wins and no scan starts.
REQ-031 reg and dim counters SHALL never wrap beyond last_reg_adr or dim 7.

Reset
REQ-032 On rst_n_i=0 the block SHALL enter IDLE, and all outputs SHALL be 0 (fe_rd_o, fe_dim_o, fe_adr_o, ram_*, all sts_*), along with the counters and latched controls.
REQ-033 Assertion of rst_n_i mid-scan SHALL abort the scan immediately with no further strobes or writes.

Verification
REQ-034 last_reg_adr=3, max_dim=4, delay=2, valid=1, bit15=0 -> 4 strobes 4 cycles apart, RAM writes at addresses 0..3, done=1, dim_count=1, busy for 16 cycles.
REQ-035 delay=0, last_reg_adr=0, bit15 set on dims 0,1 and clear on dim 2, max_dim=4 -> writes to addresses 0x00, 0x10, 0x20; dim_count=3; no error.
REQ-036 Chain flag always 1, max_dim=2, last_reg_adr=1 -> 4 writes, then err_many=1, done=1, dim_count=2.
REQ-037 fe_valid_i=0 on the 3rd word -> 2 writes only, err_fb=1, done=1, busy=0 the next cycle.
REQ-038 ctl_reset_i pulsed during WAIT of the 2nd word -> IDLE next cycle, all flags 0, no further strobe; a following trigger runs normally.
REQ-039 Trigger pulsed while busy, plus simultaneous reset and trigger in IDLE -> no restart and no scan respectively; rst_n_i low mid-scan -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/qsm_seq_if.sv
// Front-end read bus and readout-RAM write port of the chain scanner.
// The scanner drives the master side; the front end and RAM sit on the slave side.
interface qsm_seq_if;
  logic        fe_rd_o;
  logic [2:0]  fe_dim_o;
  logic [3:0]  fe_adr_o;
  logic [15:0] fe_data_i;
  logic        fe_valid_i;
  logic        ram_we_o;
  logic [6:0]  ram_addr_o;
  logic [15:0] ram_data_o;

  modport master (
    output fe_rd_o, fe_dim_o, fe_adr_o,
    input  fe_data_i, fe_valid_i,
    output ram_we_o, ram_addr_o, ram_data_o
  );

  modport slave (
    input  fe_rd_o, fe_dim_o, fe_adr_o,
    output fe_data_i, fe_valid_i,
    input  ram_we_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/qsm_seq.sv
// Daisy-chain scanner: strobes each front-end register of each dimension, waits the
// configured delay, and copies the response into the readout RAM at {dim, reg}.
module qsm_seq (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ctl_reset_i,
  input  logic       ctl_trig_i,
  input  logic [3:0] ctl_last_reg_adr_i,
  input  logic [3:0] ctl_max_dim_no_i,
  input  logic [9:0] ctl_read_delay_i,
  output logic       sts_busy_o,
  output logic       sts_done_o,
  output logic       sts_err_many_o,
  output logic       sts_err_fb_o,
  output logic [3:0] sts_dim_count_o,
  qsm_seq_if.master  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_STROBE  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_CAPTURE = 2'd3;

  logic [1:0] state_reg, state_next;
  logic [2:0] dim_reg, dim_next;
  logic [3:0] adr_reg, adr_next;
  logic [9:0] cnt_reg, cnt_next;
  logic [3:0] last_reg, last_next;
  logic [3:0] max_reg, max_next;
  logic [9:0] delay_reg, delay_next;
  logic [3:0] dim_count_reg, dim_count_next;
  logic       done_reg, done_next;
  logic       err_many_reg, err_many_next;
  logic       err_fb_reg, err_fb_next;
  logic [3:0] dim_plus1;

  assign dim_plus1 = {1'b0, dim_reg} + 4'd1;

  always_comb begin
    state_next     = state_reg;
    dim_next       = dim_reg;
    adr_next       = adr_reg;
    cnt_next       = cnt_reg;
    last_next      = last_reg;
    max_next       = max_reg;
    delay_next     = delay_reg;
    dim_count_next = dim_count_reg;
    done_next      = done_reg;
    err_many_next  = err_many_reg;
    err_fb_next    = err_fb_reg;

    if (ctl_reset_i) begin
      // Soft reset overrides everything, including a trigger in the same cycle
      state_next     = ST_IDLE;
      dim_next       = 3'd0;
      adr_next       = 4'd0;
      cnt_next       = 10'd0;
      dim_count_next = 4'd0;
      done_next      = 1'b0;
      err_many_next  = 1'b0;
      err_fb_next    = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ctl_trig_i) begin
            state_next     = ST_STROBE;
            dim_next       = 3'd0;
            adr_next       = 4'd0;
            dim_count_next = 4'd0;
            done_next      = 1'b0;
            err_many_next  = 1'b0;
            err_fb_next    = 1'b0;
            last_next      = ctl_last_reg_adr_i;
            max_next       = (ctl_max_dim_no_i > 4'd8) ? 4'd8 : ctl_max_dim_no_i;
            delay_next     = ctl_read_delay_i;
          end
        end
        ST_STROBE: begin
          if (delay_reg != 10'd0) begin
            state_next = ST_WAIT;
            cnt_next   = delay_reg - 10'd1;
          end else begin
            state_next = ST_CAPTURE;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == 10'd0) state_next = ST_CAPTURE;
          else                  cnt_next   = cnt_reg - 10'd1;
        end
        default: begin
          if (!bus.fe_valid_i) begin
            err_fb_next = 1'b1;
            done_next   = 1'b1;
            state_next  = ST_IDLE;
          end else if (adr_reg < last_reg) begin
            adr_next   = adr_reg + 4'd1;
            state_next = ST_STROBE;
          end else begin
            dim_count_next = dim_plus1;
            if (!bus.fe_data_i[15]) begin
              done_next  = 1'b1;
              state_next = ST_IDLE;
            end else if (dim_plus1 < max_reg) begin
              // max_reg never exceeds 8, so dim stays within 0..7
              dim_next   = dim_plus1[2:0];
              adr_next   = 4'd0;
              state_next = ST_STROBE;
            end else begin
              err_many_next = 1'b1;
              done_next     = 1'b1;
              state_next    = ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      dim_reg       <= 3'd0;
      adr_reg       <= 4'd0;
      cnt_reg       <= 10'd0;
      last_reg      <= 4'd0;
      max_reg       <= 4'd0;
      delay_reg     <= 10'd0;
      dim_count_reg <= 4'd0;
      done_reg      <= 1'b0;
      err_many_reg  <= 1'b0;
      err_fb_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dim_reg       <= dim_next;
      adr_reg       <= adr_next;
      cnt_reg       <= cnt_next;
      last_reg      <= last_next;
      max_reg       <= max_next;
      delay_reg     <= delay_next;
      dim_count_reg <= dim_count_next;
      done_reg      <= done_next;
      err_many_reg  <= err_many_next;
      err_fb_reg    <= err_fb_next;
    end
  end

  // Strobe and write are decoded from state so an async reset silences them at once
  assign bus.fe_rd_o    = (state_reg == ST_STROBE) && !ctl_reset_i;
  assign bus.fe_dim_o   = dim_reg;
  assign bus.fe_adr_o   = adr_reg;
  assign bus.ram_we_o   = (state_reg == ST_CAPTURE) && bus.fe_valid_i && !ctl_reset_i;
  assign bus.ram_addr_o = {dim_reg, adr_reg};
  assign bus.ram_data_o = bus.ram_we_o ? bus.fe_data_i : 16'h0000;

  assign sts_busy_o      = (state_reg != ST_IDLE);
  assign sts_done_o      = done_reg;
  assign sts_err_many_o  = err_many_reg;
  assign sts_err_fb_o    = err_fb_reg;
  assign sts_dim_count_o = dim_count_reg;

endmodule

// File: tb/tb_qsm_seq.sv
// Directed bench for qsm_seq: a small front-end model answers strobes, a negedge
// monitor logs strobes and RAM writes, and each scenario checks hand-computed results.
module tb_qsm_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ctl_reset = 1'b0;
  logic       ctl_trig = 1'b0;
  logic [3:0] ctl_last = 4'd0;
  logic [3:0] ctl_max = 4'd0;
  logic [9:0] ctl_dly = 10'd0;
  logic       busy, done, err_many, err_fb;
  logic [3:0] dim_count;

  qsm_seq_if bus ();

  qsm_seq dut (
    .clk_i              (clk),
    .rst_n_i            (rst_n),
    .ctl_reset_i        (ctl_reset),
    .ctl_trig_i         (ctl_trig),
    .ctl_last_reg_adr_i (ctl_last),
    .ctl_max_dim_no_i   (ctl_max),
    .ctl_read_delay_i   (ctl_dly),
    .sts_busy_o         (busy),
    .sts_done_o         (done),
    .sts_err_many_o     (err_many),
    .sts_err_fb_o       (err_fb),
    .sts_dim_count_o    (dim_count),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // front-end model: chain flag per dimension, data tags {dim, reg}
  logic [7:0] chain = 8'h00;
  int fail_word = 99;
  int st_base = 0;
  int st_cnt = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  int cyc = 0;
  int st_cyc [0:255];
  int wr_cyc [0:255];
  logic [6:0]  wa [0:255];
  logic [15:0] wd [0:255];

  assign bus.fe_data_i  = {chain[bus.fe_dim_o], 7'h00, 1'b0, bus.fe_dim_o, bus.fe_adr_o};
  assign bus.fe_valid_i = ((st_cnt - st_base) != fail_word);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (bus.fe_rd_o) begin
      st_cyc[st_cnt & 255] <= cyc;
      st_cnt <= st_cnt + 1;
    end
    if (bus.ram_we_o) begin
      wr_cyc[wr_cnt & 255] <= cyc;
      wa[wr_cnt & 255] <= bus.ram_addr_o;
      wd[wr_cnt & 255] <= bus.ram_data_o;
      wr_cnt <= wr_cnt + 1;
      $display("write addr=%02h data=%04h", bus.ram_addr_o, bus.ram_data_o);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  int wb, bb;

  task automatic start(input logic [3:0] last, input logic [3:0] maxd, input logic [9:0] dly);
    ctl_last = last;
    ctl_max = maxd;
    ctl_dly = dly;
    st_base = st_cnt;
    wb = wr_cnt;
    bb = busy_cnt;
    @(posedge clk); #1 ctl_trig = 1'b1;
    @(posedge clk); #1 ctl_trig = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  int s0, n;

  initial begin
    // power-on reset
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_flags", {29'd0, done, err_many, err_fb}, 32'd0);
    check("rst_dim_count", {28'd0, dim_count}, 32'd0);
    check("rst_fe", {24'd0, bus.fe_rd_o, bus.fe_dim_o, bus.fe_adr_o}, 32'd0);
    check("rst_ram", {8'd0, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic single-dimension scan; control changes after the trigger must be ignored
    chain = 8'h00;
    start(4'd3, 4'd4, 10'd2);
    ctl_last = 4'd0;
    ctl_dly = 10'd7;
    wait_idle();
    check("b_strobes", st_cnt - st_base, 4);
    check("b_strobe_gap", st_cyc[(st_base + 1) & 255] - st_cyc[st_base & 255], 4);
    check("b_strobe_span", st_cyc[(st_base + 3) & 255] - st_cyc[st_base & 255], 12);
    check("b_latency", wr_cyc[wb & 255] - st_cyc[st_base & 255], 3);
    check("b_writes", wr_cnt - wb, 4);
    check("b_addr0", {25'd0, wa[wb & 255]}, 32'h00);
    check("b_addr3", {25'd0, wa[(wb + 3) & 255]}, 32'h03);
    check("b_data3", {16'd0, wd[(wb + 3) & 255]}, 32'h0003);
    check("b_flags", {29'd0, done, err_many, err_fb}, 32'd4);
    check("b_dim_count", {28'd0, dim_count}, 32'd1);
    check("b_busy_cycles", busy_cnt - bb, 16);

    // soft reset while idle clears sticky done
    @(posedge clk); #1 ctl_reset = 1'b1;
    @(posedge clk); #1 ctl_reset = 1'b0;
    check("sr_idle_done", {31'd0, done}, 32'd0);

    // three-dimension chain, zero delay
    chain = 8'b0000_0011;
    start(4'd0, 4'd4, 10'd0);
    wait_idle();
    check("c_writes", wr_cnt - wb, 3);
    check("c_addr1", {25'd0, wa[(wb + 1) & 255]}, 32'h10);
    check("c_addr2", {25'd0, wa[(wb + 2) & 255]}, 32'h20);
    check("c_data1", {16'd0, wd[(wb + 1) & 255]}, 32'h8010);
    check("c_dim_count", {28'd0, dim_count}, 32'd3);
    check("c_flags", {29'd0, done, err_many, err_fb}, 32'd4);
    check("c_busy_cycles", busy_cnt - bb, 6);

    // chain always set, max_dim=2 -> too many dimensions
    chain = 8'hFF;
    start(4'd1, 4'd2, 10'd1);
    wait_idle();
    check("m_writes", wr_cnt - wb, 4);
    check("m_addr3", {25'd0, wa[(wb + 3) & 255]}, 32'h11);
    check("m_flags", {29'd0, done, err_many, err_fb}, 32'd6);
    check("m_dim_count", {28'd0, dim_count}, 32'd2);

    // max_dim=0 still scans dim 0
    chain = 8'h01;
    start(4'd0, 4'd0, 10'd0);
    wait_idle();
    check("z_writes", wr_cnt - wb, 1);
    check("z_flags", {29'd0, done, err_many, err_fb}, 32'd6);
    check("z_dim_count", {28'd0, dim_count}, 32'd1);

    // max_dim=12 clamps to 8
    chain = 8'hFF;
    start(4'd0, 4'd12, 10'd0);
    wait_idle();
    check("k_writes", wr_cnt - wb, 8);
    check("k_addr7", {25'd0, wa[(wb + 7) & 255]}, 32'h70);
    check("k_flags", {29'd0, done, err_many, err_fb}, 32'd6);
    check("k_dim_count", {28'd0, dim_count}, 32'd8);

    // missing response on the 3rd word
    chain = 8'h00;
    fail_word = 3;
    start(4'd3, 4'd4, 10'd1);
    wait_idle();
    fail_word = 99;
    check("f_writes", wr_cnt - wb, 2);
    check("f_flags", {29'd0, done, err_many, err_fb}, 32'd5);
    check("f_busy_cycles", busy_cnt - bb, 9);

    // soft reset during WAIT of the 2nd word
    start(4'd3, 4'd4, 10'd3);
    n = 0;
    while ((st_cnt - st_base) < 2 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("w_second_strobe", st_cnt - st_base, 2);
    @(posedge clk); #1 ctl_reset = 1'b1;
    @(posedge clk); #1 ctl_reset = 1'b0;
    @(negedge clk); #1;
    check("w_busy", {31'd0, busy}, 32'd0);
    check("w_flags", {28'd0, done, err_many, err_fb, dim_count != 4'd0}, 32'd0);
    repeat (20) @(negedge clk);
    #1;
    check("w_no_more_strobes", st_cnt - st_base, 2);
    check("w_writes", wr_cnt - wb, 1);
    start(4'd3, 4'd4, 10'd3);
    wait_idle();
    check("w_rerun_writes", wr_cnt - wb, 4);
    check("w_rerun_done", {31'd0, done}, 32'd1);

    // soft reset coinciding with the strobe cycle suppresses fe_rd
    start(4'd0, 4'd4, 10'd5);
    ctl_reset = 1'b1;
    @(negedge clk);
    check("rs_fe_rd", {31'd0, bus.fe_rd_o}, 32'd0);
    @(posedge clk); #1 ctl_reset = 1'b0;
    @(negedge clk); #1;
    check("rs_strobes", st_cnt - st_base, 0);

    // soft reset coinciding with capture suppresses the RAM write
    start(4'd0, 4'd4, 10'd0);
    @(posedge clk); #1 ctl_reset = 1'b1;
    @(negedge clk);
    check("rc_we", {31'd0, bus.ram_we_o}, 32'd0);
    @(posedge clk); #1 ctl_reset = 1'b0;
    @(negedge clk); #1;
    check("rc_writes", wr_cnt - wb, 0);
    check("rc_busy", {31'd0, busy}, 32'd0);

    // trigger while busy is ignored
    start(4'd3, 4'd4, 10'd2);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 ctl_trig = 1'b1;
    @(posedge clk); #1 ctl_trig = 1'b0;
    wait_idle();
    check("t_strobes", st_cnt - st_base, 4);
    check("t_busy_cycles", busy_cnt - bb, 16);

    // simultaneous reset and trigger in IDLE: no scan
    s0 = st_cnt;
    @(posedge clk); #1 begin ctl_trig = 1'b1; ctl_reset = 1'b1; end
    @(posedge clk); #1 begin ctl_trig = 1'b0; ctl_reset = 1'b0; end
    @(negedge clk);
    check("rt_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("rt_strobes", st_cnt - s0, 0);
    check("rt_done", {31'd0, done}, 32'd0);

    // async reset mid-scan
    start(4'd3, 4'd4, 10'd2);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    s0 = st_cnt;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_fe", {24'd0, bus.fe_rd_o, bus.fe_dim_o, bus.fe_adr_o}, 32'd0);
    check("ar_ram", {8'd0, bus.ram_we_o, bus.ram_addr_o, bus.ram_data_o}, 32'd0);
    check("ar_sts", {28'd0, dim_count} | {29'd0, done, err_many, err_fb}, 32'd0);
    wb = wr_cnt;
    repeat (6) @(negedge clk);
    #1;
    check("ar_no_strobes", st_cnt - s0, 0);
    check("ar_no_writes", wr_cnt - wb, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
